keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad and delivers one debounced 4-bit key code with a single-cycle load strobe per press.
- Sits on the input side of the game and access-control datapath. It is the counterpart of the seven-segment output path: KeyCode/KeyValid feed the password, Player 2 and digit-entry registers in place of slide switches plus a button shaper.
- One clock domain. No combinational path from Row to any output.

---
 rtl/keypad_scanner.sv | 157 +++++++++++++++
 tb/tb_keypad_scanner.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, debounces
// a single-key press/release on the synchronized rows and strobes one code per press.
module keypad_scanner #(
   parameter int SCAN_CYCLES      = 1000,
   parameter int DEBOUNCE_SAMPLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] Row,
   output logic [3:0] Col,
   output logic [3:0] KeyCode,
   output logic       KeyValid,
   output logic       KeyHeld
);

   localparam int DW = $clog2(SCAN_CYCLES);
   localparam int BW = $clog2(DEBOUNCE_SAMPLES + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
   localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_SAMPLES - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, HOLD} state_t;

   state_t        state, state_nxt;
   logic [3:0]    row_p0, row_p1;
   logic [DW-1:0] dwell_cnt;
   logic [BW-1:0] dbc, dbc_nxt;
   logic [3:0]    lat_row;
   logic          latch_row;
   logic          col_adv;
   logic          dwell_end;

   function automatic logic single_low(input logic [3:0] v);
      return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
   endfunction

   function automatic logic [1:0] low_idx(input logic [3:0] v);
      case (v)
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         4'b0111: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // rows: {1,2,3,A} {4,5,6,B} {7,8,9,C} {*,0,#,D}; A..D = 10..13, * = 14, # = 15
   function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: return 4'd1;
         4'h1: return 4'd2;
         4'h2: return 4'd3;
         4'h3: return 4'd10;
         4'h4: return 4'd4;
         4'h5: return 4'd5;
         4'h6: return 4'd6;
         4'h7: return 4'd11;
         4'h8: return 4'd7;
         4'h9: return 4'd8;
         4'hA: return 4'd9;
         4'hB: return 4'd12;
         4'hC: return 4'd14;
         4'hD: return 4'd0;
         4'hE: return 4'd15;
         default: return 4'd13;
      endcase
   endfunction

   assign dwell_end = (dwell_cnt == DWELL_LAST);

   always_comb begin
      state_nxt = state;
      dbc_nxt   = dbc;
      latch_row = 1'b0;
      col_adv   = 1'b0;
      case (state)
         SCAN: begin
            if (dwell_end) begin
               if (single_low(row_p1)) begin
                  latch_row = 1'b1;
                  dbc_nxt   = '0;
                  state_nxt = DEBOUNCE;
               end else begin
                  col_adv = 1'b1;
               end
            end
         end
         DEBOUNCE: begin
            if (dwell_end) begin
               if (row_p1 == lat_row) begin
                  if (dbc == DEB_LAST) begin
                     dbc_nxt   = '0;
                     state_nxt = PRESSED;
                  end else begin
                     dbc_nxt = dbc + 1'b1;
                  end
               end else begin
                  state_nxt = SCAN;
                  col_adv   = 1'b1;
               end
            end
         end
         PRESSED: begin
            dbc_nxt   = '0;
            state_nxt = HOLD;
         end
         HOLD: begin
            // release counter: any low row restarts the clean-sample run
            if (dwell_end) begin
               if (row_p1 == 4'hF) begin
                  if (dbc == DEB_LAST) begin
                     dbc_nxt   = '0;
                     state_nxt = SCAN;
                     col_adv   = 1'b1;
                  end else begin
                     dbc_nxt = dbc + 1'b1;
                  end
               end else begin
                  dbc_nxt = '0;
               end
            end
         end
         default: state_nxt = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= SCAN;
         row_p0    <= 4'hF;
         row_p1    <= 4'hF;
         dwell_cnt <= '0;
         dbc       <= '0;
         Col       <= 4'b1110;
         KeyCode   <= 4'd0;
         KeyValid  <= 1'b0;
         KeyHeld   <= 1'b0;
      end else begin
         // two-flop synchronizer stages
         row_p0    <= Row;
         row_p1    <= row_p0;
         dwell_cnt <= dwell_end ? '0 : dwell_cnt + 1'b1;
         state     <= state_nxt;
         dbc       <= dbc_nxt;
         if (col_adv)
            Col <= {Col[2:0], Col[3]};
         KeyValid <= (state_nxt == PRESSED);
         KeyHeld  <= (state_nxt == HOLD);
         if (state_nxt == PRESSED)
            KeyCode <= keymap(low_idx(lat_row), low_idx(Col));
      end
   end

   always_ff @(posedge clk) begin
      if (latch_row)
         lat_row <= row_p1;
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized checks of keypad_scanner against a press/release
// timing model of the keypad (SCAN_CYCLES=4, DEBOUNCE_SAMPLES=3).
module tb_keypad_scanner;

   logic        clk;
   logic        rst;
   logic [3:0]  Row;
   logic [3:0]  Col;
   logic [3:0]  KeyCode;
   logic        KeyValid;
   logic        KeyHeld;
   logic [15:0] keys;

   int n_asrt = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_strobes = 0;
   int n_long = 0;
   logic kv_prev = 1'b0;
   string lay = "123A456B789C*0#D";

   keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_SAMPLES(3)) dut (
      .clk(clk), .rst(rst), .Row(Row), .Col(Col),
      .KeyCode(KeyCode), .KeyValid(KeyValid), .KeyHeld(KeyHeld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // keys[4*r+c]: a pressed key pulls its row low only while its column is driven low
   always_comb begin
      Row    = 4'hF;
      Row[0] = ~|(keys[3:0]   & ~Col);
      Row[1] = ~|(keys[7:4]   & ~Col);
      Row[2] = ~|(keys[11:8]  & ~Col);
      Row[3] = ~|(keys[15:12] & ~Col);
   end

   always @(negedge clk) begin
      if (KeyValid) n_strobes <= n_strobes + 1;
      if (KeyValid && kv_prev) n_long <= n_long + 1;
      kv_prev <= KeyValid;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // cyc counts rising edges since reset release: dwell ends fall on cyc % 4 == 0
   task automatic tick();
      @(posedge clk);
      #1;
      if (!rst) cyc = 0;
      else cyc++;
   endtask

   function automatic int kidx(input byte ch);
      for (int i = 0; i < 16; i++)
         if (lay[i] == ch) return i;
      return 0;
   endfunction

   function automatic int kcode(input byte ch);
      int v;
      v = int'(ch);
      if (v >= 48 && v <= 57) return v - 48;       // '0'..'9'
      if (v >= 65 && v <= 68) return v - 65 + 10; // 'A'..'D'
      if (v == 42) return 14;                      // '*'
      return 15;                                   // '#'
   endfunction

   function automatic int colmask(input int i);
      return 15 & ~(1 << (i % 4));
   endfunction

   function automatic logic [15:0] key16(input int i);
      return 16'h0001 << i;
   endfunction

   // first dwell end whose sample sees a change made just after edge r0, plus two more
   function automatic int release_edge(input int r0);
      return ((r0 + 6) / 4) * 4 + 8;
   endfunction

   task automatic do_press(input byte ch, input int extra, input int exp_s);
      int p, s, r0, f, c, ki, base, ok;
      ki   = kidx(ch);
      c    = ki % 4;
      base = n_strobes;
      keys = key16(ki);
      p    = cyc;
      s    = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (KeyValid) begin
            s = cyc;
            break;
         end
      end
      if (exp_s >= 0) begin
         chk("press_strobe_cyc", s, exp_s);
      end else begin
         chk("press_strobe_phase", s % 4, 0);
         chk("press_latency_window", int'(s - p >= 15 && s - p <= 30), 1);
      end
      chk("press_code", int'(KeyCode), kcode(ch));
      tick();
      chk("press_valid_one_cycle", int'(KeyValid), 0);
      chk("press_held_next", int'(KeyHeld), 1);
      ok = (int'(Col) == colmask(c)) ? 1 : 0;
      for (int i = 0; i < extra; i++) begin
         tick();
         if (KeyHeld !== 1'b1 || int'(Col) != colmask(c)) ok = 0;
      end
      chk("hold_frozen", ok, 1);
      keys = '0;
      r0   = cyc;
      f    = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!KeyHeld) begin
            f = cyc;
            break;
         end
      end
      chk("release_cyc", f, release_edge(r0));
      chk("release_next_col", int'(Col), colmask(c + 1));
      chk("press_strobe_count", n_strobes - base, 1);
   endtask

   task automatic wait_strobe(output int s);
      s = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (KeyValid) begin
            s = cyc;
            break;
         end
      end
   endtask

   initial begin
      int s, f, a, p, r0, base, found;
      logic [3:0] prevcol;
      string seq;

      keys = '0;
      rst  = 1'b0;

      // reset and idle scan
      repeat (3) tick();
      chk("rst_col", int'(Col), 14);
      chk("rst_code", int'(KeyCode), 0);
      chk("rst_valid", int'(KeyValid), 0);
      chk("rst_held", int'(KeyHeld), 0);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_col", int'(Col), colmask(cyc / 4));
      end
      chk("idle_no_strobe", n_strobes, 0);

      // clean press of '5' from cyc 20: detected at dwell end 24, strobe at 36, released at 60
      do_press("5", 23, 36);

      // bounce: '9' seen at dwell ends 76 and 80 only
      base = n_strobes;
      keys = key16(kidx("9"));
      while (cyc < 80) tick();
      chk("bounce_col_frozen", int'(Col), 11);
      keys = '0;
      while (cyc < 84) tick();
      chk("bounce_resume_col", int'(Col), 7);
      repeat (12) tick();
      chk("bounce_no_strobe", n_strobes - base, 0);
      chk("bounce_code_kept", int'(KeyCode), 5);

      // release glitch while holding '5'
      base = n_strobes;
      p    = cyc;
      keys = key16(kidx("5"));
      wait_strobe(s);
      chk("glitch_latency_window", int'(s - p >= 15 && s - p <= 30), 1);
      tick();
      chk("glitch_held", int'(KeyHeld), 1);
      while (cyc % 4 != 0) tick();
      a    = cyc;
      keys = '0;
      while (cyc < a + 8) tick();
      keys = key16(kidx("5"));
      while (cyc < a + 12) tick();
      chk("glitch_still_held", int'(KeyHeld), 1);
      keys = '0;
      f = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!KeyHeld) begin
            f = cyc;
            break;
         end
      end
      chk("glitch_release_cyc", f, a + 24);
      chk("glitch_single_strobe", n_strobes - base, 1);
      chk("glitch_next_col", int'(Col), 11);

      // two keys in one column are never accepted
      base = n_strobes;
      keys = key16(kidx("2")) | key16(kidx("5"));
      repeat (64) tick();
      chk("multi_no_strobe", n_strobes - base, 0);
      chk("multi_not_held", int'(KeyHeld), 0);
      chk("multi_code_kept", int'(KeyCode), 5);
      keys = '0;
      repeat (4) tick();

      // code map corners
      seq = "D*#0";
      for (int i = 0; i < 4; i++) begin
         do_press(seq[i], 5, -1);
         repeat (3) tick();
      end

      // reset during DEBOUNCE with '7' held
      base    = n_strobes;
      keys    = key16(kidx("7"));
      prevcol = Col;
      found   = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (cyc % 4 == 0 && Col === prevcol && Col === 4'b1110) begin
            found = 1;
            break;
         end
         prevcol = Col;
      end
      chk("deb_entered", found, 1);
      rst = 1'b0;
      tick();
      chk("rst_deb_col", int'(Col), 14);
      chk("rst_deb_valid", int'(KeyValid), 0);
      chk("rst_deb_held", int'(KeyHeld), 0);
      chk("rst_deb_code", int'(KeyCode), 0);
      chk("deb_no_strobe", n_strobes - base, 0);
      rst = 1'b1;
      wait_strobe(s);
      chk("redetect_after_deb_cyc", s, 16);
      chk("redetect_after_deb_code", int'(KeyCode), 7);
      tick();
      chk("redetect_held", int'(KeyHeld), 1);
      repeat (3) tick();

      // reset during HOLD, key still pressed
      rst = 1'b0;
      tick();
      chk("rst_hold_col", int'(Col), 14);
      chk("rst_hold_valid", int'(KeyValid), 0);
      chk("rst_hold_held", int'(KeyHeld), 0);
      chk("rst_hold_code", int'(KeyCode), 0);
      rst = 1'b1;
      wait_strobe(s);
      chk("redetect_after_hold_cyc", s, 16);
      chk("redetect_after_hold_code", int'(KeyCode), 7);
      tick();
      keys = '0;
      r0   = cyc;
      f    = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!KeyHeld) begin
            f = cyc;
            break;
         end
      end
      chk("redetect_release_cyc", f, release_edge(r0));
      chk("redetect_next_col", int'(Col), 13);

      // random single-key presses
      for (int n = 0; n < 10; n++) begin
         int k;
         k = int'($urandom_range(15, 0));
         do_press(lay[k], int'($urandom_range(12, 0)), -1);
         repeat (int'($urandom_range(6, 0))) tick();
      end

      tick();
      chk("strobe_width", n_long, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
